psr_bank: RTL and testbench
===========================

PSR_BANK -- requirements
Module: psr_bank

Interface
REQ-001 Parameter RESET_MODE, default 5'b10011 (SVC), is the mode field loaded into the CPSR at reset.
REQ-002 clock  input  1  single rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 in_WBWriteEnable  input  1  write-back slot valid; all updates are qualified by it.
REQ-005 in_CPSR2PSR  input  32  full CPSR write data.
REQ-006 in_CPSRWriteEnable  input  1  CPSR write request.
REQ-007 in_SPSR2PSR  input  32  SPSR write data.
REQ-008 in_SPSRWriteEnable  input  1  write request for the SPSR of the current mode.
REQ-009 in_IfChangeState  input  1  exception-entry request.
REQ-010 in_ChangeStateAction  input  5  target mode for exception entry.
REQ-011 out_CPSR  output  32  registered current CPSR.
REQ-012 out_SPSR  output  32  SPSR bank of the current mode; 32'h0 in USR/SYS.
REQ-013 out_CurrentMode  output  5  equals out_CPSR[4:0].
REQ-014 out_IllegalMode  output  1  one-cycle flag for a rejected mode (PSR_MODE_CHECK_EN only; tied 0 otherwise).

Function
REQ-015 Mode encodings: USR 10000, FIQ 10001, IRQ 10010, SVC 10011, ABT 10111, UND 11011, SYS 11111.
REQ-016 State: one 32-bit CPSR register and five 32-bit SPSR banks (FIQ, IRQ, SVC, ABT, UND).
REQ-017 No state changes on a rising edge where in_WBWriteEnable==0, regardless of other inputs.
REQ-018 Exception entry (in_IfChangeState==1) saves the pre-edge CPSR into the bank of in_ChangeStateAction.
REQ-019 Exception entry sets CPSR[4:0]=in_ChangeStateAction, CPSR[5]=0 and CPSR[7]=1.
REQ-020 Exception entry sets CPSR[6]=1 only when the target is FIQ; otherwise CPSR[6] is unchanged.
REQ-021 Exception entry leaves CPSR[31:8] unchanged.
REQ-022 A CPSR write (in_CPSRWriteEnable==1) loads in_CPSR2PSR in full.
REQ-023 If a CPSR write and exception entry occur on the same edge, the CPSR write wins for the CPSR register.
REQ-024 In that case the exception entry's SPSR save still occurs.
REQ-025 An SPSR write (in_SPSRWriteEnable==1) targets the bank selected by the pre-edge mode.
REQ-026 An SPSR write while the pre-edge mode is USR or SYS is ignored.
REQ-027 If an SPSR write and an exception-entry save target the same bank on one edge, the save wins.
REQ-028 Exception entry with a target of USR or SYS updates the CPSR but saves no SPSR.
REQ-029 Latency: every write is visible on out_CPSR/out_SPSR in the cycle after the capturing edge.
REQ-030 out_SPSR is a combinational mux of the banks, indexed by the registered CPSR mode.
REQ-031 Back-to-back writes on consecutive cycles are supported with no stall and no bubble.

Reset
REQ-032 On reset low, asynchronously: CPSR=32'h0 with [7]=1, [6]=1, [4:0]=RESET_MODE (32'h000000D3 at default).
REQ-033 On reset low, asynchronously: all SPSR banks=32'h0 and out_IllegalMode=0.
REQ-034 Reset asserted mid-operation overrides any write in that cycle.
REQ-035 The first write is accepted on the first rising edge after reset deasserts.

Configuration
REQ-036 Macro PSR_MODE_CHECK_EN enables mode legality checking.
REQ-037 With PSR_MODE_CHECK_EN defined, a CPSR write or exception entry carrying a mode outside REQ-015 keeps the old CPSR[4:0], applies all other field updates, performs no SPSR save, and pulses out_IllegalMode for one cycle.
REQ-038 Without PSR_MODE_CHECK_EN, illegal modes load as-is, an illegal mode selects no bank (out_SPSR=0, SPSR writes ignored), and out_IllegalMode is constant 0.

Verification
REQ-039 Reset -> out_CPSR=32'h000000D3, out_SPSR=0, out_CurrentMode=10011.
REQ-040 From CPSR 32'h600000D3, exception entry to IRQ (10010) -> next cycle out_CPSR=32'h600000D2, out_SPSR=32'h600000D3.
REQ-041 Exception entry to FIQ from CPSR 32'h00000010 -> out_CPSR=32'h000000D1, FIQ bank=32'h00000010.
REQ-042 Same edge: CPSR write 32'h0000001F plus exception entry to ABT from 32'h000000D3 -> out_CPSR=32'h0000001F, ABT bank=32'h000000D3.
REQ-043 Any writes issued with in_WBWriteEnable=0 -> CPSR and all banks unchanged.
REQ-044 PSR_MODE_CHECK_EN defined, CPSR write 32'h00000015 from SVC -> out_CPSR[4:0]=10011, out_IllegalMode high for exactly one cycle.

Source files
------------

// File: rtl/psr_bank.sv
// CPSR plus banked SPSRs for FIQ/IRQ/SVC/ABT/UND, updated from the write-back slot.
// Optional mode legality checking is enabled with `define PSR_MODE_CHECK_EN.
module psr_bank #(
  parameter logic [4:0] RESET_MODE = 5'b10011
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_WBWriteEnable,
  input  logic [31:0] in_CPSR2PSR,
  input  logic        in_CPSRWriteEnable,
  input  logic [31:0] in_SPSR2PSR,
  input  logic        in_SPSRWriteEnable,
  input  logic        in_IfChangeState,
  input  logic [4:0]  in_ChangeStateAction,
  output logic [31:0] out_CPSR,
  output logic [31:0] out_SPSR,
  output logic [4:0]  out_CurrentMode,
  output logic        out_IllegalMode
);

  localparam logic [4:0] ModeUsr = 5'b10000;
  localparam logic [4:0] ModeFiq = 5'b10001;
  localparam logic [4:0] ModeIrq = 5'b10010;
  localparam logic [4:0] ModeSvc = 5'b10011;
  localparam logic [4:0] ModeAbt = 5'b10111;
  localparam logic [4:0] ModeUnd = 5'b11011;
  localparam logic [4:0] ModeSys = 5'b11111;

  localparam logic [2:0] NoBank = 3'd7;

  // Bank index for a mode; USR, SYS and unknown encodings have no SPSR.
  function automatic logic [2:0] bankSel(input logic [4:0] mode);
    case (mode)
      ModeFiq: bankSel = 3'd0;
      ModeIrq: bankSel = 3'd1;
      ModeSvc: bankSel = 3'd2;
      ModeAbt: bankSel = 3'd3;
      ModeUnd: bankSel = 3'd4;
      default: bankSel = NoBank;
    endcase
  endfunction

  logic [31:0]      cpsrQ, cpsrD;
  logic [4:0][31:0] spsrQ, spsrD;
  logic [2:0]       curBank, saveBank;
  logic             entryLegal, writeLegal;

`ifdef PSR_MODE_CHECK_EN
  function automatic logic isLegal(input logic [4:0] mode);
    isLegal = (bankSel(mode) != NoBank) || (mode == ModeUsr) || (mode == ModeSys);
  endfunction

  logic illegalQ, illegalD;

  assign entryLegal = isLegal(in_ChangeStateAction);
  assign writeLegal = isLegal(in_CPSR2PSR[4:0]);
  assign illegalD   = in_WBWriteEnable &
                      ((in_IfChangeState & ~entryLegal) | (in_CPSRWriteEnable & ~writeLegal));
  assign out_IllegalMode = illegalQ;

  // Flag is a pulse: it clears on the next edge whether or not the slot is valid.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) illegalQ <= 1'b0;
    else        illegalQ <= illegalD;
  end
`else
  assign entryLegal      = 1'b1;
  assign writeLegal      = 1'b1;
  assign out_IllegalMode = 1'b0;
`endif

  assign curBank  = bankSel(cpsrQ[4:0]);
  assign saveBank = bankSel(in_ChangeStateAction);

  always_comb begin
    cpsrD = cpsrQ;
    spsrD = spsrQ;
    if (in_WBWriteEnable) begin
      if (in_IfChangeState) begin
        cpsrD[7] = 1'b1;
        cpsrD[5] = 1'b0;
        if (in_ChangeStateAction == ModeFiq) cpsrD[6] = 1'b1;
        if (entryLegal) cpsrD[4:0] = in_ChangeStateAction;
      end
      // A full CPSR write overrides the exception-entry CPSR update.
      if (in_CPSRWriteEnable) begin
        cpsrD = in_CPSR2PSR;
        if (!writeLegal) cpsrD[4:0] = cpsrQ[4:0];
      end
      if (in_SPSRWriteEnable && curBank != NoBank) spsrD[curBank] = in_SPSR2PSR;
      // The exception save is applied last so it wins a same-bank collision.
      if (in_IfChangeState && entryLegal && saveBank != NoBank) spsrD[saveBank] = cpsrQ;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cpsrQ <= {24'h0, 1'b1, 1'b1, 1'b0, RESET_MODE};
      spsrQ <= '0;
    end else begin
      cpsrQ <= cpsrD;
      spsrQ <= spsrD;
    end
  end

  assign out_CPSR        = cpsrQ;
  assign out_CurrentMode = cpsrQ[4:0];
  assign out_SPSR        = (curBank == NoBank) ? 32'h0 : spsrQ[curBank];

endmodule

// File: tb/tb_psr_bank.sv
// Directed bench for psr_bank: hand-computed vectors checked with immediate assertions.
module tb_psr_bank;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_WBWriteEnable = 1'b0;
  logic [31:0] in_CPSR2PSR = '0;
  logic        in_CPSRWriteEnable = 1'b0;
  logic [31:0] in_SPSR2PSR = '0;
  logic        in_SPSRWriteEnable = 1'b0;
  logic        in_IfChangeState = 1'b0;
  logic [4:0]  in_ChangeStateAction = '0;
  logic [31:0] out_CPSR;
  logic [31:0] out_SPSR;
  logic [4:0]  out_CurrentMode;
  logic        out_IllegalMode;

  int passCount = 0;
  int totalCount = 0;

  psr_bank dut (
    .clock                (clock),
    .reset                (reset),
    .in_WBWriteEnable     (in_WBWriteEnable),
    .in_CPSR2PSR          (in_CPSR2PSR),
    .in_CPSRWriteEnable   (in_CPSRWriteEnable),
    .in_SPSR2PSR          (in_SPSR2PSR),
    .in_SPSRWriteEnable   (in_SPSRWriteEnable),
    .in_IfChangeState     (in_IfChangeState),
    .in_ChangeStateAction (in_ChangeStateAction),
    .out_CPSR             (out_CPSR),
    .out_SPSR             (out_SPSR),
    .out_CurrentMode      (out_CurrentMode),
    .out_IllegalMode      (out_IllegalMode)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    totalCount++;
    assert (observed === expected) passCount++;
    else $error("FAIL %s: observed %h expected %h", tag, observed, expected);
  endtask

  // Drive one write-back slot, let it capture on the next rising edge, then idle the inputs.
  task automatic cycle(input logic wb, input logic cwe, input logic [31:0] cdata,
                       input logic swe, input logic [31:0] sdata,
                       input logic cs, input logic [4:0] act);
    in_WBWriteEnable     = wb;
    in_CPSRWriteEnable   = cwe;
    in_CPSR2PSR          = cdata;
    in_SPSRWriteEnable   = swe;
    in_SPSR2PSR          = sdata;
    in_IfChangeState     = cs;
    in_ChangeStateAction = act;
    @(posedge clock);
    #1;
    in_WBWriteEnable     = 1'b0;
    in_CPSRWriteEnable   = 1'b0;
    in_SPSRWriteEnable   = 1'b0;
    in_IfChangeState     = 1'b0;
    in_CPSR2PSR          = '0;
    in_SPSR2PSR          = '0;
    in_ChangeStateAction = '0;
  endtask

  initial begin
    #12;
    check("reset_cpsr", out_CPSR, 32'h000000D3);
    check("reset_spsr", out_SPSR, 32'h0);
    check("reset_mode", {27'h0, out_CurrentMode}, 32'h13);
    check("reset_illegal", {31'h0, out_IllegalMode}, 32'h0);
    #1 reset = 1'b1;

    cycle(1, 1, 32'h600000D3, 0, 0, 0, 0);
    check("cpsr_write", out_CPSR, 32'h600000D3);
    check("svc_spsr_empty", out_SPSR, 32'h0);

    cycle(1, 0, 0, 1, 32'hA5A50013, 0, 0);
    check("svc_spsr_write", out_SPSR, 32'hA5A50013);

    cycle(1, 0, 0, 0, 0, 1, 5'b10010);
    check("irq_entry_cpsr", out_CPSR, 32'h600000D2);
    check("irq_entry_spsr", out_SPSR, 32'h600000D3);
    check("irq_entry_mode", {27'h0, out_CurrentMode}, 32'h12);

    cycle(0, 1, 32'hFFFFFFFF, 1, 32'h11111111, 1, 5'b10001);
    check("wb_off_cpsr", out_CPSR, 32'h600000D2);
    check("wb_off_spsr", out_SPSR, 32'h600000D3);

    cycle(1, 1, 32'h00000010, 0, 0, 0, 0);
    check("usr_cpsr", out_CPSR, 32'h00000010);
    check("usr_spsr_zero", out_SPSR, 32'h0);

    cycle(1, 0, 0, 1, 32'h12345678, 0, 0);
    check("usr_spsr_write_ignored", out_SPSR, 32'h0);

    cycle(1, 0, 0, 0, 0, 1, 5'b10001);
    check("fiq_entry_cpsr", out_CPSR, 32'h000000D1);
    check("fiq_entry_spsr", out_SPSR, 32'h00000010);

    // Back-to-back: back to SVC, then same-edge CPSR write plus ABT entry.
    cycle(1, 1, 32'h000000D3, 0, 0, 0, 0);
    check("svc_bank_kept", out_SPSR, 32'hA5A50013);
    cycle(1, 1, 32'h0000001F, 0, 0, 1, 5'b10111);
    check("write_beats_entry_cpsr", out_CPSR, 32'h0000001F);
    check("sys_spsr_zero", out_SPSR, 32'h0);
    cycle(1, 1, 32'h00000017, 0, 0, 0, 0);
    check("abt_bank_saved", out_SPSR, 32'h000000D3);

    // ABT entry from ABT with a concurrent SPSR write: the save must win.
    cycle(1, 0, 0, 1, 32'hDEADBEEF, 1, 5'b10111);
    check("save_beats_write_cpsr", out_CPSR, 32'h00000097);
    check("save_beats_write_spsr", out_SPSR, 32'h00000017);

    cycle(1, 0, 0, 0, 0, 1, 5'b10000);
    check("usr_entry_cpsr", out_CPSR, 32'h00000090);
    cycle(1, 1, 32'h00000017, 0, 0, 0, 0);
    check("usr_entry_no_save", out_SPSR, 32'h00000017);

    // Illegal mode 10101 written from SVC.
    cycle(1, 1, 32'h000000D3, 0, 0, 0, 0);
    cycle(1, 1, 32'h00000015, 0, 0, 0, 0);
`ifdef PSR_MODE_CHECK_EN
    check("illegal_cpsr_kept_mode", out_CPSR, 32'h00000013);
    check("illegal_flag_high", {31'h0, out_IllegalMode}, 32'h1);
    check("illegal_spsr", out_SPSR, 32'hA5A50013);
    cycle(1, 0, 0, 0, 0, 0, 0);
    check("illegal_flag_pulse", {31'h0, out_IllegalMode}, 32'h0);
`else
    check("illegal_cpsr_loaded", out_CPSR, 32'h00000015);
    check("illegal_flag_low", {31'h0, out_IllegalMode}, 32'h0);
    check("illegal_spsr_zero", out_SPSR, 32'h0);
    cycle(1, 0, 0, 1, 32'h55555555, 0, 0);
    check("illegal_spsr_write_ignored", out_SPSR, 32'h0);
`endif

    // Asynchronous reset mid-cycle with a write pending.
    in_WBWriteEnable   = 1'b1;
    in_CPSRWriteEnable = 1'b1;
    in_CPSR2PSR        = 32'hFFFFFFFF;
    #2 reset = 1'b0;
    #1;
    check("async_reset_cpsr", out_CPSR, 32'h000000D3);
    @(posedge clock);
    #1;
    check("reset_overrides_write", out_CPSR, 32'h000000D3);
    in_WBWriteEnable   = 1'b0;
    in_CPSRWriteEnable = 1'b0;
    #2 reset = 1'b1;
    cycle(1, 1, 32'h000000D2, 0, 0, 0, 0);
    check("first_write_after_reset", out_CPSR, 32'h000000D2);
    check("irq_bank_cleared", out_SPSR, 32'h0);

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
